// File: rtl/serial_link_credit_ctrl.sv
// Per-VC credit flow control for the serial link data-link layer: round-robin data grant,
// TX credit tracking, RX credit return. Define SERIAL_LINK_CREDIT_STALL_CNT_EN for stall counters.
module serial_link_credit_ctrl #(
    parameter int unsigned  NumVc           = 2,
    parameter int unsigned  NumCredits      = 8,
    parameter int unsigned  ForceSendThresh = NumCredits - 1,
    localparam int unsigned VcW             = (NumVc > 1) ? $clog2(NumVc) : 1,
    localparam int unsigned CreditW         = $clog2(NumCredits) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [NumVc-1:0]           in_valid_i,
    output logic [NumVc-1:0]           in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [VcW-1:0]             out_vc_o,
    output logic                       out_credit_only_o,
    output logic [VcW-1:0]             out_credit_vc_o,
    output logic [CreditW-1:0]         out_credits_o,
    input  logic [NumVc-1:0]           rx_consume_i,
    input  logic                       credit_in_valid_i,
    input  logic [VcW-1:0]             credit_in_vc_i,
    input  logic [CreditW-1:0]         credit_in_i,
    output logic [NumVc*CreditW-1:0]   avail_o,
    output logic                       credit_err_o
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
   ,output logic [NumVc*32-1:0]        stall_cnt_o
`endif
);
    typedef logic [CreditW-1:0] cnt_t;
    localparam logic [CreditW:0] MaxCnt  = (CreditW+1)'(NumCredits);
    localparam cnt_t             InitCnt = CreditW'(NumCredits);

    cnt_t             avail_q [NumVc];
    cnt_t             avail_d [NumVc];
    cnt_t             pend_q  [NumVc];
    cnt_t             pend_d  [NumVc];
    logic [CreditW:0] avail_sum [NumVc];
    logic [CreditW:0] pend_sum  [NumVc];
    logic             err_q, err_d, lock_q;
    logic [VcW-1:0]   rr_q, rr_d, lk_vc_q, lk_cvc_q;
    logic             lk_co_q;
    cnt_t             lk_cr_q;
    logic [NumVc-1:0] elig;
    logic             any_elig, hs, data_hs;
    logic [VcW-1:0]   idx, grant_vc, best_vc;
    cnt_t             best_pend;

    always_comb begin : arb
        any_elig  = 1'b0;
        grant_vc  = '0;
        idx       = '0;
        best_vc   = '0;
        best_pend = pend_q[0];
        for (int v = 0; v < NumVc; v++) elig[v] = in_valid_i[v] && (avail_q[v] != '0);
        // First eligible VC scanning upward from the round-robin pointer
        for (int k = 0; k < NumVc; k++) begin
            idx = VcW'((int'(rr_q) + k) % int'(NumVc));
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                grant_vc = idx;
            end
        end
        // Strict '>' keeps ties on the lowest index
        for (int v = 1; v < NumVc; v++) begin
            if (pend_q[v] > best_pend) begin
                best_pend = pend_q[v];
                best_vc   = VcW'(v);
            end
        end
    end

    always_comb begin : outsel
        out_valid_o       = 1'b0;
        out_vc_o          = '0;
        out_credit_only_o = 1'b0;
        out_credit_vc_o   = '0;
        out_credits_o     = '0;
        if (!clear_i) begin
            if (lock_q) begin
                out_valid_o       = 1'b1;
                out_vc_o          = lk_vc_q;
                out_credit_only_o = lk_co_q;
                out_credit_vc_o   = lk_cvc_q;
                out_credits_o     = lk_cr_q;
            end else if (any_elig) begin
                out_valid_o     = 1'b1;
                out_vc_o        = grant_vc;
                out_credit_vc_o = best_vc;
                out_credits_o   = best_pend;
            end else if (best_pend >= CreditW'(ForceSendThresh)) begin
                out_valid_o       = 1'b1;
                out_credit_only_o = 1'b1;
                out_credit_vc_o   = best_vc;
                out_credits_o     = best_pend;
            end
        end
        in_ready_o = '0;
        for (int v = 0; v < NumVc; v++)
            in_ready_o[v] = out_ready_i && out_valid_o && !out_credit_only_o && (out_vc_o == VcW'(v));
    end

    always_comb begin : nxt
        hs      = out_valid_o && out_ready_i;
        data_hs = hs && !out_credit_only_o;
        err_d   = err_q;
        rr_d    = rr_q;
        for (int v = 0; v < NumVc; v++) begin
            // Credits returned are the presented value, so consumes during a lock stay pending
            avail_sum[v] = {1'b0, avail_q[v]}
                         + ((credit_in_valid_i && credit_in_vc_i == VcW'(v)) ? {1'b0, credit_in_i} : '0)
                         - ((data_hs && out_vc_o == VcW'(v)) ? (CreditW+1)'(1) : '0);
            pend_sum[v]  = {1'b0, pend_q[v]} + (CreditW+1)'(rx_consume_i[v])
                         - ((hs && out_credit_vc_o == VcW'(v)) ? {1'b0, out_credits_o} : '0);
            avail_d[v] = avail_sum[v][CreditW-1:0];
            pend_d[v]  = pend_sum[v][CreditW-1:0];
            if (avail_sum[v] > MaxCnt) begin
                avail_d[v] = InitCnt;
                err_d      = 1'b1;
            end
            if (pend_sum[v] > MaxCnt) begin
                pend_d[v] = InitCnt;
                err_d     = 1'b1;
            end
        end
        if (data_hs) rr_d = (out_vc_o == VcW'(NumVc - 1)) ? '0 : out_vc_o + VcW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v] <= InitCnt;
                pend_q[v]  <= '0;
            end
            err_q <= 1'b0;  rr_q <= '0;  lock_q <= 1'b0;
            lk_vc_q <= '0;  lk_co_q <= 1'b0;  lk_cvc_q <= '0;  lk_cr_q <= '0;
        end else if (clear_i) begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v] <= InitCnt;
                pend_q[v]  <= '0;
            end
            err_q <= 1'b0;  rr_q <= '0;  lock_q <= 1'b0;
        end else begin
            avail_q <= avail_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
            lock_q  <= out_valid_o && !out_ready_i;
            if (out_valid_o && !out_ready_i) begin
                lk_vc_q  <= out_vc_o;
                lk_co_q  <= out_credit_only_o;
                lk_cvc_q <= out_credit_vc_o;
                lk_cr_q  <= out_credits_o;
            end
        end
    end

    always_comb begin
        avail_o = '0;
        for (int v = 0; v < NumVc; v++) avail_o[v*CreditW +: CreditW] = avail_q[v];
    end
    assign credit_err_o = err_q;

`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
    logic [31:0] stall_q [NumVc];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < NumVc; v++) stall_q[v] <= '0;
        end else if (clear_i) begin
            for (int v = 0; v < NumVc; v++) stall_q[v] <= '0;
        end else begin
            for (int v = 0; v < NumVc; v++)
                if (in_valid_i[v] && avail_q[v] == '0 && stall_q[v] != '1) stall_q[v] <= stall_q[v] + 32'd1;
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int v = 0; v < NumVc; v++) stall_cnt_o[v*32 +: 32] = stall_q[v];
    end
`endif
endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// Bench for serial_link_credit_ctrl (NumVc=2, NumCredits=8): vector table, directed corner
// sequences, then random traffic against a behavioural credit model.
module tb_serial_link_credit_ctrl;
    localparam int NV = 2, NC = 8, TH = 7;

    logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic [1:0] iv = '0, rc = '0, in_ready;
    logic       rdy = 1'b0, civ = 1'b0, civc = 1'b0;
    logic [3:0] ci = '0, credits;
    logic       out_valid, out_vc, out_co, out_cvc, err;
    logic [7:0] avail;
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
    logic [63:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    serial_link_credit_ctrl #(.NumVc(NV), .NumCredits(NC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(iv), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_ready_i(rdy), .out_vc_o(out_vc),
        .out_credit_only_o(out_co), .out_credit_vc_o(out_cvc), .out_credits_o(credits),
        .rx_consume_i(rc), .credit_in_valid_i(civ), .credit_in_vc_i(civc), .credit_in_i(ci),
        .avail_o(avail), .credit_err_o(err)
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
       ,.stall_cnt_o(stall_cnt)
`endif
    );

    int checks = 0, errors = 0;

    typedef struct packed {
        logic v; logic vc; logic co; logic cvc; logic [3:0] cr; logic [1:0] rdy;
    } beat_t;

    typedef struct {
        logic [1:0] iv; logic rdy; logic [1:0] rc; logic civ; logic civc; logic [3:0] ci; logic clr;
        beat_t exp; logic [7:0] av; logic err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t dut_beat();
        beat_t a;
        a = {out_valid, out_vc, out_co, out_cvc, credits, in_ready};
        return a;
    endfunction

    task automatic drv(input logic [1:0] iv_, input logic rdy_, input logic [1:0] rc_,
                       input logic civ_, input logic civc_, input logic [3:0] ci_, input logic clr_);
        iv = iv_; rdy = rdy_; rc = rc_; civ = civ_; civc = civc_; ci = ci_; clear = clr_;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] iv_, input logic rdy_, input logic [1:0] rc_,
                                input logic civ_, input logic civc_, input logic [3:0] ci_, input logic clr_,
                                input logic v, input logic vc, input logic co, input logic cvc,
                                input logic [3:0] cr, input logic [1:0] er, input logic [7:0] av, input logic e);
        vec_t t;
        t.iv = iv_; t.rdy = rdy_; t.rc = rc_; t.civ = civ_; t.civc = civc_; t.ci = ci_; t.clr = clr_;
        t.exp = {v, vc, co, cvc, cr, er}; t.av = av; t.err = e;
        return t;
    endfunction

    // Behavioural model: per-VC credit counts and the beat currently held by back-pressure
    int    m_avail[NV], m_pend[NV], m_rr;
    longint m_stall[NV];
    bit    m_err, m_lock;
    beat_t m_lb;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_avail[v] = NC; m_pend[v] = 0; m_stall[v] = 0;
        end
        m_err = 0; m_rr = 0; m_lock = 0; m_lb = '0;
    endtask

    function automatic beat_t model_beat(input logic [1:0] iv_, input logic rdy_, input logic clr_);
        beat_t b;
        int g, vv, bp, best;
        b = '0; g = -1; bp = -1; best = 0;
        for (int v = 0; v < NV; v++) if (m_pend[v] > bp) begin bp = m_pend[v]; best = v; end
        if (clr_) return b;
        if (m_lock) b = m_lb;
        else begin
            for (int k = 0; k < NV; k++) begin
                vv = (m_rr + k) % NV;
                if (g < 0 && iv_[vv] && m_avail[vv] > 0) g = vv;
            end
            if (g >= 0)       b = {1'b1, 1'(g), 1'b0, 1'(best), 4'(bp), 2'b00};
            else if (bp >= TH) b = {1'b1, 1'b0, 1'b1, 1'(best), 4'(bp), 2'b00};
        end
        b.rdy = (b.v && rdy_ && !b.co) ? (2'b01 << b.vc) : 2'b00;
        return b;
    endfunction

    task automatic model_step(input logic [1:0] iv_, input logic rdy_, input logic [1:0] rc_,
                              input logic civ_, input logic civc_, input logic [3:0] ci_,
                              input logic clr_, input beat_t b);
        int a, p;
        bit hs;
        if (clr_) begin model_reset(); return; end
        hs = b.v && rdy_;
        for (int v = 0; v < NV; v++) begin
            if (iv_[v] && m_avail[v] == 0 && m_stall[v] < 64'hFFFF_FFFF) m_stall[v]++;
            a = m_avail[v] + ((civ_ && civc_ == v) ? int'(ci_) : 0) - ((hs && !b.co && b.vc == v) ? 1 : 0);
            p = m_pend[v] + int'(rc_[v]) - ((hs && b.cvc == v) ? int'(b.cr) : 0);
            if (a > NC) begin a = NC; m_err = 1; end
            if (p > NC) begin p = NC; m_err = 1; end
            m_avail[v] = a; m_pend[v] = p;
        end
        if (hs && !b.co) m_rr = (int'(b.vc) + 1) % NV;
        m_lock = b.v && !rdy_;
        if (m_lock) m_lb = b;
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        logic [1:0] nxt_iv, last_rdy;
        beat_t eb;

        // iv rdy rc civ civc ci clr | v vc co cvc cr rdy | avail err
        tbl.push_back(mk(2'b00,0,2'b00,0,0,0,0, 0,0,0,0,0,2'b00, 8'h88,0));
        tbl.push_back(mk(2'b11,1,2'b00,0,0,0,0, 1,0,0,0,0,2'b01, 8'h88,0));
        tbl.push_back(mk(2'b11,1,2'b00,0,0,0,0, 1,1,0,0,0,2'b10, 8'h87,0));
        tbl.push_back(mk(2'b11,0,2'b01,0,0,0,0, 1,0,0,0,0,2'b00, 8'h77,0));
        tbl.push_back(mk(2'b11,0,2'b00,0,0,0,0, 1,0,0,0,0,2'b00, 8'h77,0));
        tbl.push_back(mk(2'b11,1,2'b00,0,0,0,0, 1,0,0,0,0,2'b01, 8'h77,0));
        tbl.push_back(mk(2'b10,1,2'b10,0,0,0,0, 1,1,0,0,1,2'b10, 8'h76,0));
        tbl.push_back(mk(2'b00,1,2'b00,1,1,2,0, 0,0,0,0,0,2'b00, 8'h66,0));
        tbl.push_back(mk(2'b00,1,2'b00,1,0,3,0, 0,0,0,0,0,2'b00, 8'h86,0));
        tbl.push_back(mk(2'b00,0,2'b00,0,0,0,0, 0,0,0,0,0,2'b00, 8'h88,1));
        tbl.push_back(mk(2'b11,1,2'b00,0,0,0,1, 0,0,0,0,0,2'b00, 8'h88,1));
        tbl.push_back(mk(2'b00,0,2'b00,0,0,0,0, 0,0,0,0,0,2'b00, 8'h88,0));

        @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_avail", 32'(avail), 32'h88);
        tick();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drv(tbl[i].iv, tbl[i].rdy, tbl[i].rc, tbl[i].civ, tbl[i].civc, tbl[i].ci, tbl[i].clr);
            @(negedge clk);
            chk($sformatf("tbl%0d_beat", i), 32'(dut_beat()), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_avail", i), 32'(avail), 32'(tbl[i].av));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
            tick();
        end

        // Forced credit-only beat after seven consumes on VC1
        for (int i = 0; i < 7; i++) begin
            drv(2'b00, 0, 2'b10, 0, 0, 0, 0);
            @(negedge clk);
            chk("conly_wait", 32'(out_valid), 32'd0);
            tick();
        end
        drv(2'b00, 1, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("conly_beat", 32'(dut_beat()), 32'({1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 2'b00}));
        tick();
        drv(2'b00, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("conly_drained", 32'(out_valid), 32'd0);
        tick();

        // Piggy-back: pend 2/2, VC1 data beat returns VC0, with a consume in the same cycle
        repeat (2) begin drv(2'b00, 0, 2'b11, 0, 0, 0, 0); tick(); end
        drv(2'b10, 1, 2'b01, 0, 0, 0, 0);
        @(negedge clk);
        chk("piggy1", 32'(dut_beat()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 2'b10}));
        tick();
        drv(2'b10, 1, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("piggy2", 32'(dut_beat()), 32'({1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 2'b10}));
        tick();
        @(negedge clk);
        chk("piggy3", 32'(dut_beat()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 2'b10}));
        tick();
        drv(2'b00, 0, 2'b00, 0, 0, 0, 1);
        tick();

        // Drain VC0 credits, then refill with three
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drv(2'b01, 1, 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            n += int'(in_ready[0]);
            tick();
        end
        chk("drain_count", 32'(n), 32'd8);
        @(negedge clk);
        chk("drain_avail0", 32'(avail[3:0]), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd0);
        tick();
        drv(2'b00, 0, 2'b00, 1, 0, 4'd3, 0);
        tick();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drv(2'b01, 1, 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            n += int'(in_ready[0]);
            tick();
        end
        chk("refill_count", 32'(n), 32'd3);
        drv(2'b00, 0, 2'b00, 0, 0, 0, 1);
        tick();

        // Stall for exactly five cycles, then async reset between clock edges
        for (int i = 0; i < 13; i++) begin drv(2'b01, 1, 2'b00, 0, 0, 0, 0); tick(); end
        @(negedge clk);
        chk("stall_avail0", 32'(avail[3:0]), 32'd0);
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
        chk("stall_cnt5", stall_cnt[31:0], 32'd5);
`endif
        iv = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_avail", 32'(avail), 32'h88);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
        chk("async_rst_stall", stall_cnt[31:0], 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        model_reset();

        // Random traffic against the model; requests hold until accepted
        last_rdy = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < NV; v++)
                nxt_iv[v] = (iv[v] && !last_rdy[v]) ? 1'b1 : ($urandom_range(0, 99) < 50);
            drv(nxt_iv, $urandom_range(0, 99) < 75,
                {1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 30)},
                $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                $urandom_range(0, 199) == 0);
            eb = model_beat(iv, rdy, clear);
            @(negedge clk);
            chk("rnd_beat", 32'(dut_beat()), 32'(eb));
            chk("rnd_avail", 32'(avail), 32'({4'(m_avail[1]), 4'(m_avail[0])}));
            chk("rnd_err", 32'(err), 32'(m_err));
`ifdef SERIAL_LINK_CREDIT_STALL_CNT_EN
            chk("rnd_stall0", stall_cnt[31:0], 32'(m_stall[0]));
            chk("rnd_stall1", stall_cnt[63:32], 32'(m_stall[1]));
`endif
            last_rdy = eb.rdy;
            @(posedge clk);
            model_step(iv, rdy, rc, civ, civc, ci, clear, eb);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
